// File: rtl/input_control_if.sv
// Bus bundle for input_control: serial load handshake in, skewed array-edge feed out.
interface input_control_if #(
   parameter int D_W = 8,
   parameter int N   = 2
);
   logic             data_in;
   logic             data_valid;
   logic             load_ready;
   logic [N*D_W-1:0] core_in_a;
   logic [N*D_W-1:0] core_in_b;
   logic             core_valid;
   logic             init;
   logic             load_abort;

   modport master (
      output data_in, data_valid,
      input  load_ready, core_in_a, core_in_b, core_valid, init, load_abort
   );

   modport slave (
      input  data_in, data_valid,
      output load_ready, core_in_a, core_in_b, core_valid, init, load_abort
   );
endinterface

// File: rtl/input_control.sv
// Deserialises matrices A and B from a bit stream, then replays them diagonally skewed
// into the systolic array edges. Optional idle-timeout abort under INPUT_TIMEOUT_EN.
module input_control #(
   parameter int D_W    = 8,
   parameter int N      = 2,
   parameter int TO_CYC = 64
) (
   input logic             clk,
   input logic             rst_n,
   input_control_if.slave  bus
);
   localparam int NE = 2 * N * N;
   localparam int NF = 2 * N - 1;
   localparam int BW = (D_W > 1) ? $clog2(D_W) : 1;
   localparam int EW = (NE > 1) ? $clog2(NE) : 1;
   localparam int FW = (NF > 1) ? $clog2(NF) : 1;

   typedef enum logic [1:0] {LOAD, FEED, DONE} state_t;

   state_t           state_reg;
   logic [BW-1:0]    bit_cnt_reg;
   logic [EW-1:0]    elem_cnt_reg;
   logic [FW-1:0]    feed_cnt_reg;
   logic [D_W-1:0]   mem_reg [NE];
   logic             load_ready_reg;
   logic             core_valid_reg;
   logic             init_reg;
   logic [N*D_W-1:0] core_a_reg;
   logic [N*D_W-1:0] core_b_reg;
   logic [N*D_W-1:0] slot_a;
   logic [N*D_W-1:0] slot_b;

   // Lane gi sees element (feed_cnt - gi); anything outside 0..N-1 is a zero bubble.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_lane
         logic [FW:0]    diff;
         logic [D_W-1:0] lane_a;
         logic [D_W-1:0] lane_b;

         always_comb begin
            diff   = {1'b0, feed_cnt_reg} - (FW+1)'(gi);
            lane_a = '0;
            lane_b = '0;
            if (diff < (FW+1)'(N)) begin
               lane_a = mem_reg[EW'(gi * N) + EW'(diff)];
               lane_b = mem_reg[EW'(N * N) + EW'(diff) * EW'(N) + EW'(gi)];
            end
         end

         assign slot_a[gi*D_W +: D_W] = lane_a;
         assign slot_b[gi*D_W +: D_W] = lane_b;
      end
   endgenerate

`ifdef INPUT_TIMEOUT_EN
   localparam int IW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
   logic [IW-1:0] idle_cnt_reg;
   logic          load_abort_reg;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= LOAD;
         bit_cnt_reg    <= '0;
         elem_cnt_reg   <= '0;
         feed_cnt_reg   <= '0;
         load_ready_reg <= 1'b1;
         core_valid_reg <= 1'b0;
         init_reg       <= 1'b0;
         core_a_reg     <= '0;
         core_b_reg     <= '0;
         for (int k = 0; k < NE; k++) mem_reg[k] <= '0;
`ifdef INPUT_TIMEOUT_EN
         idle_cnt_reg   <= '0;
         load_abort_reg <= 1'b0;
`endif
      end else begin
         init_reg <= 1'b0;
`ifdef INPUT_TIMEOUT_EN
         load_abort_reg <= 1'b0;
`endif
         case (state_reg)
            LOAD: begin
               if (bus.data_valid) begin
                  mem_reg[elem_cnt_reg][bit_cnt_reg] <= bus.data_in;
`ifdef INPUT_TIMEOUT_EN
                  idle_cnt_reg <= '0;
`endif
                  if (bit_cnt_reg == BW'(D_W - 1)) begin
                     bit_cnt_reg <= '0;
                     if (elem_cnt_reg == EW'(NE - 1)) begin
                        elem_cnt_reg   <= '0;
                        feed_cnt_reg   <= '0;
                        load_ready_reg <= 1'b0;
                        state_reg      <= FEED;
                     end else begin
                        elem_cnt_reg <= elem_cnt_reg + EW'(1);
                     end
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + BW'(1);
                  end
               end
`ifdef INPUT_TIMEOUT_EN
               // Nonzero counters mean the current stream has started.
               else if (bit_cnt_reg != '0 || elem_cnt_reg != '0) begin
                  if (idle_cnt_reg == IW'(TO_CYC - 1)) begin
                     load_abort_reg <= 1'b1;
                     bit_cnt_reg    <= '0;
                     elem_cnt_reg   <= '0;
                     idle_cnt_reg   <= '0;
                  end else begin
                     idle_cnt_reg <= idle_cnt_reg + IW'(1);
                  end
               end
`endif
            end
            FEED: begin
               core_valid_reg <= 1'b1;
               core_a_reg     <= slot_a;
               core_b_reg     <= slot_b;
               if (feed_cnt_reg == FW'(NF - 1)) begin
                  feed_cnt_reg <= '0;
                  state_reg    <= DONE;
               end else begin
                  feed_cnt_reg <= feed_cnt_reg + FW'(1);
               end
            end
            DONE: begin
               core_valid_reg <= 1'b0;
               core_a_reg     <= '0;
               core_b_reg     <= '0;
               init_reg       <= 1'b1;
               load_ready_reg <= 1'b1;
               state_reg      <= LOAD;
            end
            default: state_reg <= LOAD;
         endcase
      end
   end

   assign bus.load_ready = load_ready_reg;
   assign bus.core_in_a  = core_a_reg;
   assign bus.core_in_b  = core_b_reg;
   assign bus.core_valid = core_valid_reg;
   assign bus.init       = init_reg;
`ifdef INPUT_TIMEOUT_EN
   assign bus.load_abort = load_abort_reg;
`else
   assign bus.load_abort = 1'b0;
`endif

endmodule
